// File: rtl/my_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_pkg
// Purpose  : Shared data/address widths and the one-hot bus T-state encoding.
// Revision : 1.0 - adds bus_tstate_t and ADDR_WIDTH_DEF for the bus initiator
// ============================================================================
package my_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int ADDR_WIDTH_DEF = 20;

    typedef enum logic [5:0] {
        TI = 6'b000001,
        T1 = 6'b000010,
        T2 = 6'b000100,
        T3 = 6'b001000,
        TW = 6'b010000,
        T4 = 6'b100000
    } bus_tstate_t;

    // States in which the active-low RD/WR strobe of the current cycle is asserted.
    function automatic logic is_strobe_state(input bus_tstate_t s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_wait_timer
// Purpose  : Counts TW states of one bus cycle and flags when MAX_WAIT is reached.
// Revision : 1.0 - initial release
// ============================================================================
module bus_wait_timer
#(
    parameter int MAX_WAIT = 15
)
(
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the limit so a stalled FSM can never wrap the count.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            r_count <= '0;
        end else if (incr && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count >= CNT_W'(MAX_WAIT));

endmodule
`default_nettype wire

// File: rtl/bus_cycle_initiator.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_initiator
// Purpose  : 8088-style bus master turning one handshake request into a T1-T4
//            demultiplexed bus cycle. Define BUS_TIMEOUT_EN to abort stuck waits.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_initiator
    import my_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_WAIT   = 15
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_iom,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    output logic                  ALE,
    output logic                  IOM,
    output logic                  RD,
    output logic                  WR,
    input  logic                  READY,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in
);

    bus_tstate_t           r_state;
    bus_tstate_t           w_state_nxt;
    logic                  r_write;
    logic                  r_iom;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_strobe;
    logic                  w_drive;

`ifdef BUS_TIMEOUT_EN
    logic w_timeout;
    logic w_expired;
    logic r_timeout;

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (r_state == T2),
        .incr    (w_state_nxt == TW),
        .expired (w_expired)
    );

    // High exactly during the T4 that follows a timeout abort.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
        end
    end

    assign rsp_error = r_timeout;
`else
    // MAX_WAIT only shapes the timeout build; keep it referenced here.
    if (MAX_WAIT > 0) begin : g_wait_limit_unused
    end

    assign rsp_error = 1'b0;
`endif

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= TI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ALE         = 1'b0;
        busy        = 1'b1;
`ifdef BUS_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        unique case (r_state)
            TI: begin
                busy      = 1'b0;
                req_ready = !RESET;
                if (req_valid && !RESET) begin
                    w_state_nxt = T1;
                end
            end
            T1: begin
                ALE         = 1'b1;
                w_state_nxt = T2;
            end
            T2: begin
                w_state_nxt = T3;
            end
            T3, TW: begin
                if (READY) begin
                    w_state_nxt = T4;
                    w_done      = 1'b1;
`ifdef BUS_TIMEOUT_EN
                end else if ((r_state == TW) && w_expired) begin
                    w_state_nxt = T4;
                    w_timeout   = 1'b1;
`endif
                end else begin
                    w_state_nxt = TW;
                end
            end
            T4: begin
                rsp_valid   = !RESET;
                req_ready   = !RESET;
                w_state_nxt = req_valid ? T1 : TI;
            end
            default: begin
                w_state_nxt = TI;
            end
        endcase
    end

    // Request fields are frozen on accept so Address/IOM stay stable T1..T4.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_write <= 1'b0;
            r_iom   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_iom   <= req_iom;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_done && !r_write) begin
                r_rdata <= data_in;
`ifdef BUS_TIMEOUT_EN
            end else if (w_timeout) begin
                r_rdata <= '0;
`endif
            end
        end
    end

    assign w_strobe  = is_strobe_state(r_state);
    assign w_drive   = r_write && (w_strobe || (r_state == T4));
    assign RD        = !(w_strobe && !r_write);
    assign WR        = !(w_strobe && r_write);
    assign IOM       = r_iom;
    assign Address   = r_addr;
    assign rsp_rdata = r_rdata;
    assign data_out  = w_drive ? r_wdata : 'z;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_initiator
// Purpose  : Directed checks of bus_cycle_initiator against a 256-byte responder stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_initiator;
    import my_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  req_valid, req_ready, req_write, req_iom;
    logic [19:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid, rsp_error, busy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  ALE, IOM, RD, WR, READY;
    logic [19:0]           Address;
    wire  [DATA_WIDTH-1:0] data_out;
    wire  [DATA_WIDTH-1:0] data_in;

    logic [7:0] mem [256];
    logic       mem_load;
    logic [7:0] load_addr, load_data;

    int total = 0;
    int bad   = 0;

    bus_cycle_initiator #(.ADDR_WIDTH(20), .MAX_WAIT(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .busy(busy), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .READY(READY),
        .Address(Address), .data_out(data_out), .data_in(data_in)
    );

    always #5 CLK = ~CLK;

    // Responder stub: combinational read, write on each clock WR is low.
    assign data_in = mem[Address[7:0]];
    always @(posedge CLK) begin
        if (mem_load) mem[load_addr] <= load_data;
        else if (!WR) mem[Address[7:0]] <= data_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        mem_load = 1'b1; load_addr = a; load_data = d;
        @(negedge CLK);
        mem_load = 1'b0;
    endtask

    // Presents a request from idle; the next negedge after return is T1.
    task automatic issue(input logic w, input logic io, input logic [19:0] a, input logic [7:0] d);
        @(negedge CLK);
        req_valid = 1'b1; req_write = w; req_iom = io; req_addr = a; req_wdata = d;
        #1 check("ready_idle", req_ready, 1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_iom = 1'b0;
        req_addr = '0; req_wdata = '0; READY = 1'b1; mem_load = 1'b0;
        load_addr = '0; load_data = '0;
        repeat (2) cyc();
        check("rst_ale", ALE, 0);
        check("rst_rd", RD, 1);
        check("rst_wr", WR, 1);
        check("rst_iom", IOM, 0);
        check("rst_addr", Address, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_req_ready", req_ready, 0);
        load(8'h05, 8'hA5);
        load(8'h20, 8'h77);
        cyc();
        RESET = 1'b0;

        // IO read of 0xA5 at 0x1C05, zero wait
        issue(1'b0, 1'b1, 20'h1C05, 8'h00);
        cyc();
        check("rd_t1_ale", ALE, 1);
        check("rd_t1_addr", Address, 20'h1C05);
        check("rd_t1_iom", IOM, 1);
        check("rd_t1_rd", RD, 1);
        check("rd_t1_busy", busy, 1);
        cyc();
        check("rd_t2_rd", RD, 0);
        check("rd_t2_ale", ALE, 0);
        cyc();
        check("rd_t3_rd", RD, 0);
        check("rd_t3_valid", rsp_valid, 0);
        cyc();
        check("rd_t4_valid", rsp_valid, 1);
        check("rd_t4_rdata", rsp_rdata, 8'hA5);
        check("rd_t4_rd", RD, 1);
        check("rd_t4_ready", req_ready, 1);
        check("rd_t4_addr", Address, 20'h1C05);
        cyc();
        check("rd_ti_busy", busy, 0);
        check("rd_ti_valid", rsp_valid, 0);

        // Write 0x3C to 0x1C10, then read it back
        issue(1'b1, 1'b0, 20'h1C10, 8'h3C);
        cyc();
        check("wr_t1_wr", WR, 1);
        check("wr_t1_ale", ALE, 1);
        check("wr_t1_iom", IOM, 0);
        check("wr_t1_dout_off", data_out == 8'h3C, 0);
        cyc();
        check("wr_t2_wr", WR, 0);
        check("wr_t2_rd", RD, 1);
        check("wr_t2_dout", data_out, 8'h3C);
        cyc();
        check("wr_t3_wr", WR, 0);
        check("wr_t3_dout", data_out, 8'h3C);
        cyc();
        check("wr_t4_wr", WR, 1);
        check("wr_t4_dout", data_out, 8'h3C);
        check("wr_t4_valid", rsp_valid, 1);
        cyc();
        check("wr_ti_busy", busy, 0);
        check("wr_ti_dout_off", data_out == 8'h3C, 0);
        issue(1'b0, 1'b0, 20'h1C10, 8'h00);
        repeat (3) cyc();
        cyc();
        check("rb_t4_valid", rsp_valid, 1);
        check("rb_t4_rdata", rsp_rdata, 8'h3C);

        // READY low for T3 and two TWs, released in the third TW
        READY = 1'b0;
        issue(1'b0, 1'b1, 20'h1C05, 8'h00);
        repeat (3) cyc();
        check("ws_t3_rd", RD, 0);
        cyc();
        check("ws_tw1_rd", RD, 0);
        check("ws_tw1_busy", busy, 1);
        check("ws_tw1_valid", rsp_valid, 0);
        cyc();
        check("ws_tw2_rd", RD, 0);
        mem_load = 1'b1; load_addr = 8'h05; load_data = 8'h5A;
        cyc();
        mem_load = 1'b0;
        check("ws_tw3_rd", RD, 0);
        check("ws_tw3_valid", rsp_valid, 0);
        check("ws_tw3_rdata_old", rsp_rdata, 8'h3C);
        READY = 1'b1;
        cyc();
        check("ws_t4_valid", rsp_valid, 1);
        check("ws_t4_rdata", rsp_rdata, 8'h5A);
        cyc();
        check("ws_ti_busy", busy, 0);

        // Three back-to-back reads with req_valid held high
        cyc();
        req_valid = 1'b1; req_write = 1'b0; req_iom = 1'b0; req_addr = 20'h1C05;
        @(posedge CLK);
        #1;
        pulses = 0;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            if (rsp_valid) pulses++;
            if (c == 4)  check("b2b_rdata1", rsp_rdata, 8'h5A);
            if (c == 5)  check("b2b_t1_ale2", ALE, 1);
            if (c == 5)  check("b2b_addr2", Address, 20'h1C10);
            if (c == 8)  check("b2b_rdata2", rsp_rdata, 8'h3C);
            if (c == 9)  check("b2b_t1_ale3", ALE, 1);
            if (c == 12) check("b2b_rdata3", rsp_rdata, 8'h77);
            if (c == 13) check("b2b_idle", busy, 0);
            if (c == 1)  req_addr = 20'h1C10;
            if (c == 5)  req_addr = 20'h1C20;
            if (c == 9)  req_valid = 1'b0;
        end
        check("b2b_pulses", pulses, 3);

        // Reset during T2 of a write
        issue(1'b1, 1'b0, 20'h1C30, 8'h99);
        cyc();
        cyc();
        check("rst_t2_wr", WR, 0);
        RESET = 1'b1;
        cyc();
        check("rst_mid_wr", WR, 1);
        check("rst_mid_ale", ALE, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_dout_off", data_out == 8'h99, 0);
        RESET = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (rsp_valid) pulses++;
        end
        check("rst_no_rsp", pulses, 0);

        // READY stuck low
        READY = 1'b0;
        issue(1'b0, 1'b1, 20'h1C05, 8'h00);
`ifdef BUS_TIMEOUT_EN
        repeat (18) cyc();
        check("to_tw15_valid", rsp_valid, 0);
        check("to_tw15_rd", RD, 0);
        cyc();
        check("to_t4_valid", rsp_valid, 1);
        check("to_t4_error", rsp_error, 1);
        check("to_t4_rdata", rsp_rdata, 0);
        cyc();
        check("to_ti_busy", busy, 0);
        check("to_ti_error", rsp_error, 0);
        READY = 1'b1;
`else
        repeat (23) cyc();
        check("nto_tw_rd", RD, 0);
        check("nto_tw_busy", busy, 1);
        check("nto_tw_valid", rsp_valid, 0);
        check("nto_tw_error", rsp_error, 0);
        READY = 1'b1;
        cyc();
        check("nto_t4_valid", rsp_valid, 1);
        check("nto_t4_error", rsp_error, 0);
        check("nto_t4_rdata", rsp_rdata, 8'h5A);
        cyc();
        check("nto_ti_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
